// File: rtl/stepper_pkg.sv
// Shared types and default timing for the two-axis step/direction pulser.
package stepper_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    DONE  = 3'd4
  } pulser_state_t;

  // Defaults also used by the controller to size its own wait timers.
  localparam int DEF_COUNT_W            = 8;
  localparam int DEF_DIR_SETUP_CYCLES   = 20;
  localparam int DEF_PULSE_HIGH_CYCLES  = 100;
  localparam int DEF_STEP_PERIOD_CYCLES = 2000;
  localparam int DEF_TIMER_W            = 16;

endpackage

// File: rtl/step_interval_timer.sv
// Loadable down-counter; holds at zero and flags it so the FSM can
// reload it on every state transition.
module step_interval_timer #(
  parameter int TIMER_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  output logic               zero_o
);

  logic [TIMER_W-1:0] count_q;

  // Reload on request, otherwise count down and stop at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - TIMER_W'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/dual_stepper_pulser.sv
// Latches one move command and drives step/direction pins for two
// stepper drivers; both motors pulse in lockstep until each has emitted
// its commanded count, then the block reports ready again.
//
// state | meaning
// IDLE  | ready for a command, waiting for a dataReady rising edge
// SETUP | direction pins settled, waiting before the first step edge
// HIGH  | step pulse high for every motor with steps remaining
// LOW   | remainder of the step period, pins low
// DONE  | single-cycle busy acknowledge for a zero/zero command
module dual_stepper_pulser
  import stepper_pkg::*;
#(
  parameter int COUNT_W            = DEF_COUNT_W,
  parameter int DIR_SETUP_CYCLES   = DEF_DIR_SETUP_CYCLES,
  parameter int PULSE_HIGH_CYCLES  = DEF_PULSE_HIGH_CYCLES,
  parameter int STEP_PERIOD_CYCLES = DEF_STEP_PERIOD_CYCLES,
  parameter int TIMER_W            = DEF_TIMER_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COUNT_W-1:0] steps1,
  input  logic [COUNT_W-1:0] steps2,
  input  logic               dir1,
  input  logic               dir2,
  input  logic               dataReady,
  output logic               stepperReady,
  output logic               step1,
  output logic               step2,
  output logic               dirOut1,
  output logic               dirOut2,
  output logic               busy
);

  localparam logic [TIMER_W-1:0] SETUP_LD = TIMER_W'(DIR_SETUP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] HIGH_LD  = TIMER_W'(PULSE_HIGH_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOW_LD   =
    TIMER_W'(STEP_PERIOD_CYCLES - PULSE_HIGH_CYCLES - 1);

  pulser_state_t      state_q, state_d;
  logic [COUNT_W-1:0] rem1_q, rem1_d, rem2_q, rem2_d;
  logic               dir1_q, dir1_d, dir2_q, dir2_d;
  logic               step1_q, step1_d, step2_q, step2_d;
  logic               ready_q, ready_d;
  logic               dr_q;
  logic               load;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_zero;

  step_interval_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // Edge detector resets high so a level already asserted at reset
  // release is not mistaken for a new command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dr_q <= 1'b1;
    else        dr_q <= dataReady;
  end

  assign load = dataReady && !dr_q && (state_q == IDLE);

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d  = state_q;
    rem1_d   = rem1_q;
    rem2_d   = rem2_q;
    dir1_d   = dir1_q;
    dir2_d   = dir2_q;
    step1_d  = step1_q;
    step2_d  = step2_q;
    ready_d  = ready_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      IDLE: begin
        if (load) begin
          rem1_d  = steps1;
          rem2_d  = steps2;
          dir1_d  = dir1;
          dir2_d  = dir2;
          ready_d = 1'b0;
          if (steps1 == '0 && steps2 == '0) begin
            state_d = DONE;
          end else begin
            state_d  = SETUP;
            tmr_load = 1'b1;
            tmr_val  = SETUP_LD;
          end
        end
      end
      SETUP: begin
        if (tmr_zero) begin
          state_d  = HIGH;
          tmr_load = 1'b1;
          tmr_val  = HIGH_LD;
          step1_d  = (rem1_q != '0);
          step2_d  = (rem2_q != '0);
        end
      end
      HIGH: begin
        if (tmr_zero) begin
          if (rem1_q != '0) rem1_d = rem1_q - COUNT_W'(1);
          if (rem2_q != '0) rem2_d = rem2_q - COUNT_W'(1);
          step1_d  = 1'b0;
          step2_d  = 1'b0;
          state_d  = LOW;
          tmr_load = 1'b1;
          tmr_val  = LOW_LD;
        end
      end
      LOW: begin
        if (tmr_zero) begin
          if (rem1_q == '0 && rem2_q == '0) begin
            state_d = IDLE;
            ready_d = 1'b1;
          end else begin
            state_d  = HIGH;
            tmr_load = 1'b1;
            tmr_val  = HIGH_LD;
            step1_d  = (rem1_q != '0);
            step2_d  = (rem2_q != '0);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        step1_d = 1'b0;
        step2_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops step pins immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rem1_q  <= '0;
      rem2_q  <= '0;
      dir1_q  <= 1'b0;
      dir2_q  <= 1'b0;
      step1_q <= 1'b0;
      step2_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      rem1_q  <= rem1_d;
      rem2_q  <= rem2_d;
      dir1_q  <= dir1_d;
      dir2_q  <= dir2_d;
      step1_q <= step1_d;
      step2_q <= step2_d;
      ready_q <= ready_d;
    end
  end

  assign stepperReady = ready_q;
  assign busy         = ~ready_q;
  assign step1        = step1_q;
  assign step2        = step2_q;
  assign dirOut1      = dir1_q;
  assign dirOut2      = dir2_q;

endmodule

// File: tb/tb_dual_stepper_pulser.sv
// Scoreboard bench: stimulus queues the expected move summary for each
// command, a negedge monitor measures every move and compares.
module tb_dual_stepper_pulser;

  localparam int CW     = 8;
  localparam int SETUP  = 3;
  localparam int PH     = 2;
  localparam int PERIOD = 5;

  typedef struct {
    int n1;
    int n2;
    bit d1;
    bit d2;
    int dur;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [CW-1:0] steps1 = '0, steps2 = '0;
  logic          dir1 = 1'b0, dir2 = 1'b0;
  logic          dataReady = 1'b1;
  logic          stepperReady, step1, step2, dirOut1, dirOut2, busy;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t q[$];

  dual_stepper_pulser #(
    .COUNT_W(CW), .DIR_SETUP_CYCLES(SETUP), .PULSE_HIGH_CYCLES(PH),
    .STEP_PERIOD_CYCLES(PERIOD), .TIMER_W(16)
  ) dut (
    .clk(clk), .reset(reset), .steps1(steps1), .steps2(steps2),
    .dir1(dir1), .dir2(dir2), .dataReady(dataReady),
    .stepperReady(stepperReady), .step1(step1), .step2(step2),
    .dirOut1(dirOut1), .dirOut2(dirOut2), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: a move lasts the direction setup plus one full step
  // period per step of the longer axis; an empty move is a 1-cycle blip.
  function automatic exp_t model(input int n1, input int n2, input bit d1, input bit d2);
    exp_t e;
    e.n1 = n1; e.n2 = n2; e.d1 = d1; e.d2 = d2;
    e.dur = (n1 == 0 && n2 == 0) ? 1 : SETUP + ((n1 > n2) ? n1 : n2) * PERIOD;
    return e;
  endfunction

  // Monitor: measures each move and compares it with the queued summary.
  bit   in_move = 0, have_exp = 0;
  bit   pr = 1, ps1 = 0, ps2 = 0;
  int   start = 0, p1 = 0, p2 = 0, last1 = 0, last2 = 0, hi1 = 0, hi2 = 0;
  exp_t cur;

  always @(negedge clk) begin
    if (!reset) begin
      in_move = 0; pr = 1; ps1 = 0; ps2 = 0; hi1 = 0; hi2 = 0;
    end else begin
      chk("busy_inverse", int'(busy), int'(!stepperReady));
      if (pr && !stepperReady) begin
        in_move = 1; start = cyc; p1 = 0; p2 = 0; hi1 = 0; hi2 = 0;
        if (q.size() == 0) begin
          have_exp = 0;
          chk("unexpected_move", 1, 0);
        end else begin
          have_exp = 1;
          cur = q.pop_front();
          chk("dir1_at_load", int'(dirOut1), int'(cur.d1));
          chk("dir2_at_load", int'(dirOut2), int'(cur.d2));
        end
      end
      if (in_move) begin
        if (step1 && !ps1) begin
          p1++;
          if (p1 == 1) chk("step1_first_edge", cyc - start, SETUP);
          else         chk("step1_period", cyc - last1, PERIOD);
          last1 = cyc;
        end
        if (step2 && !ps2) begin
          p2++;
          if (p2 == 1) chk("step2_first_edge", cyc - start, SETUP);
          else         chk("step2_period", cyc - last2, PERIOD);
          last2 = cyc;
        end
        if (!step1 && ps1) begin chk("step1_high_width", hi1, PH); hi1 = 0; end
        if (!step2 && ps2) begin chk("step2_high_width", hi2, PH); hi2 = 0; end
        if (step1) hi1++;
        if (step2) hi2++;
      end
      if (!pr && stepperReady && in_move) begin
        in_move = 0;
        if (have_exp) begin
          chk("step1_pulses", p1, cur.n1);
          chk("step2_pulses", p2, cur.n2);
          chk("move_duration", cyc - start, cur.dur);
          chk("dir1_held", int'(dirOut1), int'(cur.d1));
          chk("dir2_held", int'(dirOut2), int'(cur.d2));
        end
      end
      if (stepperReady) chk("idle_steps_low", int'({step1, step2}), 0);
      pr = stepperReady; ps1 = step1; ps2 = step2;
    end
  end

  task automatic wait_ready(input int bound);
    int n = 0;
    @(negedge clk);
    while (!stepperReady && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!stepperReady) chk("ready_timeout", 0, 1);
  endtask

  // Issue one command as a one-cycle dataReady pulse, expecting a load.
  task automatic issue(input int n1, input int n2, input bit d1, input bit d2);
    @(posedge clk); #1;
    steps1 = CW'(n1); steps2 = CW'(n2); dir1 = d1; dir2 = d2;
    dataReady = 1'b1;
    q.push_back(model(n1, n2, d1, d2));
    @(posedge clk); #1;
    dataReady = 1'b0;
    steps1 = CW'($urandom); steps2 = CW'($urandom);
    dir1 = 1'($urandom); dir2 = 1'($urandom);
    wait_ready(300 * PERIOD);
  endtask

  initial begin
    int n;
    // Reset held with dataReady already high.
    repeat (5) @(posedge clk);
    #1;
    chk("rst_ready", int'(stepperReady), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_steps", int'({step1, step2}), 0);
    chk("rst_dirs", int'({dirOut1, dirOut2}), 0);
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("no_load_on_high_level", int'(stepperReady), 1);
    dataReady = 1'b0;
    repeat (2) @(posedge clk);

    issue(3, 1, 1'b1, 1'b0);
    issue(0, 0, 1'b1, 1'b1);
    issue(1, 4, 1'b0, 1'b1);
    issue(0, 2, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      int a, b;
      a = $urandom_range(0, 6);
      b = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 6);
      issue(a, b, 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    // Level held long then toggled mid-move: only the first edge loads.
    @(posedge clk); #1;
    steps1 = 8'd5; steps2 = 8'd2; dir1 = 1'b0; dir2 = 1'b1;
    dataReady = 1'b1;
    q.push_back(model(5, 2, 1'b0, 1'b1));
    repeat (10) @(posedge clk);
    #1;
    steps1 = 8'd9; steps2 = 8'd9; dir1 = 1'b1; dir2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dataReady = 1'b0; @(posedge clk); #1;
      dataReady = 1'b1; @(posedge clk); #1;
    end
    dataReady = 1'b0;
    wait_ready(100 * PERIOD);
    repeat (10) @(posedge clk);

    // Reset during a step pulse.
    @(posedge clk); #1;
    steps1 = 8'd4; steps2 = 8'd4; dir1 = 1'b1; dir2 = 1'b1;
    dataReady = 1'b1;
    q.push_back(model(4, 4, 1'b1, 1'b1));
    @(posedge clk); #1;
    dataReady = 1'b0;
    n = 0;
    @(negedge clk);
    while (!step1 && n < 50) begin @(negedge clk); n++; end
    chk("mid_move_reached_high", int'(step1), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_steps", int'({step1, step2}), 0);
    chk("async_rst_ready", int'(stepperReady), 1);
    chk("async_rst_dirs", int'({dirOut1, dirOut2}), 0);
    q.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("post_rst_idle", int'(stepperReady), 1);

    // Full-scale count on one axis.
    issue(255, 0, 1'b1, 1'b0);
    issue(2, 255, 1'b0, 1'b1);

    repeat (5) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dual_stepper_pulser.md
Name: dual_stepper_pulser

Overview:
Downstream consumer of the SCARA controller's step command interface (steps1/steps2, dir1/dir2, dataReady) and producer of its stepperReady handshake. It latches one move command and drives step/direction pins for two stepper drivers. Each step period both motors pulse together until each has emitted its commanded count. It then re-asserts stepperReady so the controller can issue the next move.

Parameters:
COUNT_W, 8, width of per-motor step count; matches controller steps1/steps2
DIR_SETUP_CYCLES, 20, clk cycles between direction pin update and first step edge (>=1)
PULSE_HIGH_CYCLES, 100, step pulse high time in clk cycles (>=1)
STEP_PERIOD_CYCLES, 2000, rising-edge-to-rising-edge step period (> PULSE_HIGH_CYCLES)
TIMER_W, 16, width of internal interval counter; must hold the largest of the three cycle parameters

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (low = reset)
steps1  input  COUNT_W  motor 1 step count; sampled on load
steps2  input  COUNT_W  motor 2 step count; sampled on load
dir1  input  1  motor 1 direction; sampled on load
dir2  input  1  motor 2 direction; sampled on load
dataReady  input  1  command valid level from controller; its rising edge is the load strobe
stepperReady  output  1  high when idle and able to accept a command
step1  output  1  motor 1 step pulse
step2  output  1  motor 2 step pulse
dirOut1  output  1  motor 1 direction pin; held for the whole move
dirOut2  output  1  motor 2 direction pin; held for the whole move
busy  output  1  high while a move is in progress; equals ~stepperReady

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; stepperReady=1; busy=0.
  - step1=step2=0; dirOut1=dirOut2=0.
  - Remaining counts and timer cleared.
  - dataReady edge register set to 1, so a level already high at reset release is not a load.
- Load:
  - A load is a rising edge of dataReady (dataReady=1 and the registered previous value=0) while in IDLE.
  - Rising edges in any other state are ignored and not queued.
  - On load: rem1<=steps1, rem2<=steps2, dirOut1<=dir1, dirOut2<=dir2.
  - stepperReady falls on the next clock edge.
- States (all outputs registered):
  - IDLE: stepperReady=1. On load with both counts zero go to DONE; on any other load go to SETUP with timer=DIR_SETUP_CYCLES-1.
  - SETUP: step pins low. At timer=0 go to HIGH with timer=PULSE_HIGH_CYCLES-1.
  - HIGH: stepN=1 iff remN!=0. At timer=0, decrement each nonzero remN, clear step pins, and go to LOW with timer=STEP_PERIOD_CYCLES-PULSE_HIGH_CYCLES-1.
  - LOW: step pins low. At timer=0 go to IDLE if rem1=rem2=0, else go to HIGH.
  - DONE: one-cycle state, then IDLE. A zero/zero command holds stepperReady low for exactly 1 cycle.
- Timing:
  - Move duration from the load cycle to stepperReady high = DIR_SETUP_CYCLES + max(steps1,steps2)*STEP_PERIOD_CYCLES cycles.
  - The motor with the smaller count stops pulsing early; its pin stays low.
- Arithmetic:
  - Counts are unsigned and decremented only when nonzero; they never wrap.
  - steps=2^COUNT_W-1 yields exactly that many pulses.
- Direction pins change only on load, never mid-move.
- Reset mid-move forces the reset values immediately (async): step pins drop with no glitch extension, and the pending move is discarded.

Decomposition:
- Package stepper_pkg holds:
  - typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DONE} pulser_state_t
  - default timing constants shared with the controller's wait-timer sizing.
- Sub-module step_interval_timer: a loadable down-counter of width TIMER_W with load, load value, and zero flag. Instantiated once and reloaded at each state transition.

Test Plan:
- Reset: hold reset=0 for 5 cycles with dataReady=1, then release → stepperReady=1, step pins 0, dir pins 0, and no move starts while dataReady stays high.
- Basic move: params SETUP=3, HIGH=2, PERIOD=5; pulse dataReady 0→1 with steps1=3, steps2=1, dir1=1, dir2=0 → expected response:
  - stepperReady=0 next cycle; dirOut1=1, dirOut2=0.
  - First step edge 3 cycles after load.
  - step1 gives 3 pulses, 2 cycles high, 5-cycle period; step2 gives 1 pulse coincident with step1's first.
  - stepperReady=1 exactly 18 cycles after load.
- Zero command: steps1=steps2=0 → stepperReady low exactly 1 cycle, no step pulses, dir pins updated.
- Ignored strobes: hold dataReady high 10 cycles, then toggle it during the move → exactly one move executed, with pulse counts per the first command.
- Reset mid-move: assert reset during a HIGH phase → step pins 0 in the same cycle, stepperReady=1 after release, no further pulses.
- Max count: steps1=255, steps2=0 → exactly 255 step1 pulses, step2 never high, no wrap-around.
